// File: rtl/vec_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_issue_pkg
// Purpose  : Shared constants for the vector issue queue. Holds the vector
//            opcodes, the instruction field positions, the funct6 codes of
//            long-latency ops, and the long-op classifier.
// Revision : 1.0  initial release
// ============================================================================
package vec_issue_pkg;

  localparam logic [6:0] OP_V  = 7'b1010111;
  localparam logic [6:0] OP_VL = 7'b0000111;
  localparam logic [6:0] OP_VS = 7'b0100111;

  // Instruction field positions (LSBs; widths are fixed by the ISA)
  localparam int F_OPC_LSB = 0;   // [6:0]
  localparam int F_VD_LSB  = 7;   // [11:7]
  localparam int F_F3_LSB  = 12;  // [14:12]
  localparam int F_VS1_LSB = 15;  // [19:15]
  localparam int F_VS2_LSB = 20;  // [24:20]
  localparam int F_VM_BIT  = 25;  // [25]
  localparam int F_F6_LSB  = 26;  // [31:26]

  // funct6 codes that take the long pipe when funct3 is 010 or 110
  localparam int LONG_F6_N = 6;
  localparam logic [LONG_F6_N-1:0][5:0] LONG_F6 = {
    6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101001, 6'b101101
  };

  function automatic logic is_long_op(input logic [2:0] funct3,
                                      input logic [5:0] funct6);
    logic f6_hit;
    f6_hit = 1'b0;
    for (int i = 0; i < LONG_F6_N; i++) begin
      if (funct6 == LONG_F6[i]) f6_hit = 1'b1;
    end
    return (funct3 == 3'b001) || (funct3 == 3'b101) ||
           (((funct3 == 3'b010) || (funct3 == 3'b110)) && f6_hit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_issue_if
// Purpose  : Bundles the scalar-core push side, the decode-side issue
//            handshake, load completion, flush and occupancy.
//   master : scalar core / decode / load unit side (drives push, ready,
//            load_done, flush)
//   slave  : the issue queue (drives push_ready, head packet, valid, count)
// Revision : 1.0  initial release
// ============================================================================
interface vec_issue_if #(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int FIFO_DEPTH       = 4
);
  logic                          push_valid;
  logic [DATA_FROM_SCALAR-1:0]   push_data;
  logic                          push_ready;
  logic [DATA_FROM_SCALAR-1:0]   instruction_out;
  logic                          valid_instruction;
  logic                          ready_vector;
  logic                          load_done;
  logic [4:0]                    load_done_id;
  logic                          flush;
  logic [$clog2(FIFO_DEPTH):0]   count;

  modport master (
    output push_valid, push_data, ready_vector, load_done, load_done_id, flush,
    input  push_ready, instruction_out, valid_instruction, count
  );

  modport slave (
    input  push_valid, push_data, ready_vector, load_done, load_done_id, flush,
    output push_ready, instruction_out, valid_instruction, count
  );
endinterface
`default_nettype wire

// File: rtl/vec_issue_queue_busy_table.sv
`default_nettype none
// ============================================================================
// Module   : vec_busy_table
// Purpose  : Per-vector-register busy state: a down-counter for ALU/MUL ops
//            and a load-pending bit. Four read ports report busy status.
// Ports    : clk, rst            clock, async active-high reset
//            i_set_*             mark a register busy on issue
//            i_clr_en/i_clr_id   load write-back clears load_pend
//            i_rd_id[3:0]        registers to query
//            o_busy[3:0]         busy flag per query
// Revision : 1.0  initial release
// ============================================================================
module vec_busy_table #(
  parameter int LAT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set_en,
  input  logic [4:0]           i_set_id,
  input  logic [LAT_W-1:0]     i_set_lat,
  input  logic                 i_set_load,
  input  logic                 i_clr_en,
  input  logic [4:0]           i_clr_id,
  input  logic [3:0][4:0]      i_rd_id,
  output logic [3:0]           o_busy
);

  logic [LAT_W-1:0] r_cnt [32];
  logic [31:0]      r_load_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      r_load_pend <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - LAT_W'(1);
      end
      // A new issue overrides the decrement of the same register
      if (i_set_en && !i_set_load) r_cnt[i_set_id] <= i_set_lat;
      if (i_clr_en) r_load_pend[i_clr_id] <= 1'b0;
      if (i_set_en && i_set_load) r_load_pend[i_set_id] <= 1'b1;
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_rd
    assign o_busy[j] = (r_cnt[i_rd_id[j]] != '0) || r_load_pend[i_rd_id[j]];
  end

endmodule
`default_nettype wire

// File: rtl/vec_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : vec_issue_queue
// Purpose  : In-order packet FIFO in front of vector decode with a register
//            hazard scoreboard. The head is offered (valid_instruction) only
//            when none of its source registers or its destination is busy.
// Ports    : clk, rst   clock, async active-high reset
//            bus        vec_issue_if.slave (push, issue, load_done, flush,
//                       count)
//            stall_cycles  (only with VEC_ISSUE_STATS_EN) cycles the head
//                          was held by a hazard
// Options  : VEC_ISSUE_STATS_EN enables the stall_cycles counter/port.
// Revision : 1.0  initial release
// ============================================================================
module vec_issue_queue
  import vec_issue_pkg::*;
#(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int INSTRUCTION_BITS = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int ALU_LATENCY      = 3,
  parameter int MUL_LATENCY      = 6
) (
  input  logic        clk,
  input  logic        rst,
  vec_issue_if.slave  bus
`ifdef VEC_ISSUE_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(MUL_LATENCY + 1);

  logic [DATA_FROM_SCALAR-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wptr;
  logic [PTR_W-1:0]            r_rptr;
  logic [CNT_W-1:0]            r_count;

  logic [DATA_FROM_SCALAR-1:0] w_head;
  logic [INSTRUCTION_BITS-1:0] w_ins;
  logic [6:0] w_opc;
  logic [4:0] w_vd, w_vs1, w_vs2;
  logic [2:0] w_f3;
  logic [5:0] w_f6;
  logic       w_vm;
  logic       w_is_v, w_is_vl, w_is_vs;
  logic [3:0] w_need, w_busy;
  logic       w_hazard, w_empty, w_full, w_valid, w_push, w_pop;

  assign w_head = r_mem[r_rptr];
  assign w_ins  = w_head[DATA_FROM_SCALAR-1 -: INSTRUCTION_BITS];
  assign w_opc  = w_ins[F_OPC_LSB +: 7];
  assign w_vd   = w_ins[F_VD_LSB  +: 5];
  assign w_f3   = w_ins[F_F3_LSB  +: 3];
  assign w_vs1  = w_ins[F_VS1_LSB +: 5];
  assign w_vs2  = w_ins[F_VS2_LSB +: 5];
  assign w_vm   = w_ins[F_VM_BIT];
  assign w_f6   = w_ins[F_F6_LSB  +: 6];

  assign w_is_v  = (w_opc == OP_V);
  assign w_is_vl = (w_opc == OP_VL);
  assign w_is_vs = (w_opc == OP_VS);

  // need[0]=vs1, need[1]=vs2, need[2]=vd, need[3]=v0.
  // vd is a WAW check for OP_V/OP_VL and store data for OP_VS.
  // funct6[0] set on a memory op means an indexed mode (vs2 is the index).
  assign w_need[0] = w_is_v && (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010);
  assign w_need[1] = w_is_v || ((w_is_vl || w_is_vs) && w_f6[0]);
  assign w_need[2] = w_is_v || w_is_vl || w_is_vs;
  assign w_need[3] = !w_vm;

  assign w_hazard = |(w_need & w_busy);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_valid  = !w_empty && !bus.flush && !w_hazard;
  assign w_push   = bus.push_valid && !w_full && !bus.flush;
  assign w_pop    = w_valid && bus.ready_vector;

  assign bus.push_ready        = !w_full;
  assign bus.instruction_out   = w_head;
  assign bus.valid_instruction = w_valid;
  assign bus.count             = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= bus.push_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The counter holds the cycles still busy after the issue edge, so a
  // dependent sees it reach zero in time to issue LATENCY edges later.
  logic [LAT_W-1:0] w_set_lat;
  assign w_set_lat = is_long_op(w_f3, w_f6) ? LAT_W'(MUL_LATENCY - 1)
                                            : LAT_W'(ALU_LATENCY - 1);

  vec_busy_table #(.LAT_W(LAT_W)) u_busy (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_pop && (w_is_v || w_is_vl)),
    .i_set_id   (w_vd),
    .i_set_lat  (w_set_lat),
    .i_set_load (w_is_vl),
    .i_clr_en   (bus.load_done),
    .i_clr_id   (bus.load_done_id),
    .i_rd_id    ({5'd0, w_vd, w_vs2, w_vs1}),
    .o_busy     (w_busy)
  );

`ifdef VEC_ISSUE_STATS_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall_cycles <= '0;
    else if (!w_empty && !bus.flush && w_hazard) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_issue_queue
// Purpose  : Directed self-checking bench for vec_issue_queue. Accepted
//            packets go to a scoreboard queue; every issue is compared with
//            the queue head and its edge number is logged for latency checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_vec_issue_queue;
  import vec_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int ALU_L = 3;
  localparam int MUL_L = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_issue_if #(.DATA_FROM_SCALAR(96), .FIFO_DEPTH(DEPTH)) bus ();

`ifdef VEC_ISSUE_STATS_EN
  logic [31:0] stall;
`endif

  vec_issue_queue #(
    .DATA_FROM_SCALAR(96), .INSTRUCTION_BITS(32), .FIFO_DEPTH(DEPTH),
    .ALU_LATENCY(ALU_L), .MUL_LATENCY(MUL_L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef VEC_ISSUE_STATS_EN
    ,
    .stall_cycles (stall)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [95:0] exp_q [$];
  int          issue_q [$];
  int          push_edge;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue monitor: an issue happens at the coming edge
  always @(negedge clk) begin
    logic [95:0] want;
    if (!rst && bus.valid_instruction === 1'b1 && bus.ready_vector === 1'b1) begin
      want = (exp_q.size() != 0) ? exp_q[0] : 'x;
      checks++;
      assert (exp_q.size() != 0 && bus.instruction_out === want) else begin
        errors++;
        $error("FAIL issue_data observed=%h expected=%h", bus.instruction_out, want);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      issue_q.push_back(cyc + 1);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] ins(input logic [5:0] f6, input logic vm,
                                      input logic [4:0] vs2, input logic [4:0] vs1,
                                      input logic [2:0] f3, input logic [4:0] vd,
                                      input logic [6:0] opc);
    return {f6, vm, vs2, vs1, f3, vd, opc};
  endfunction

  function automatic logic [31:0] vadd(input logic [4:0] vd, input logic [4:0] vs1,
                                       input logic [4:0] vs2, input logic vm);
    return ins(6'b000000, vm, vs2, vs1, 3'b000, vd, OP_V);
  endfunction

  function automatic logic [31:0] vmul(input logic [4:0] vd, input logic [4:0] vs1,
                                       input logic [4:0] vs2);
    return ins(6'b100101, 1'b1, vs2, vs1, 3'b010, vd, OP_V);
  endfunction

  // Model accepts a push when its occupancy (scoreboard size) is below DEPTH
  task automatic push(input logic [31:0] instr);
    logic [95:0] pkt;
    pkt = {instr, 32'($urandom()), 32'($urandom())};
    bus.push_valid = 1'b1;
    bus.push_data  = pkt;
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(pkt);
      push_edge = cyc + 1;
    end
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n);
    int b;
    b = 0;
    while (issue_q.size() < n && b < 100) begin
      tick();
      b++;
    end
    chk("issue_timeout", 128'(issue_q.size() >= n), 128'd1);
  endtask

  initial begin
    int pe [4];
    int p;
    int m;
`ifdef VEC_ISSUE_STATS_EN
    logic [31:0] stall0;
`endif
    bus.push_valid   = 1'b0;
    bus.push_data    = '0;
    bus.ready_vector = 1'b0;
    bus.load_done    = 1'b0;
    bus.load_done_id = '0;
    bus.flush        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_push_ready", bus.push_ready, 1);
    chk("rst_valid", bus.valid_instruction, 0);
    chk("rst_instr", bus.instruction_out, 0);
    chk("rst_count", bus.count, 0);

    // Four independent adds stream through, one cycle each
    bus.ready_vector = 1'b1;
    issue_q.delete();
    for (int i = 0; i < 4; i++) begin
      push(vadd(5'(i + 1), 5'd20, 5'd21, 1'b1));
      pe[i] = push_edge;
      chk("t1_count", bus.count, 1);
    end
    wait_issues(4);
    for (int i = 0; i < 4; i++) chk("t1_issue_edge", issue_q[i], pe[i] + 1);
    chk("t1_count_end", bus.count, 0);
    idle(8);

    // Fill while decode stalls; fifth push is refused
    bus.ready_vector = 1'b0;
    issue_q.delete();
    for (int i = 0; i < 5; i++) begin
      push(vadd(5'(11 + i), 5'd20, 5'd21, 1'b1));
      if (i == 3) begin
        chk("t2_push_ready_full", bus.push_ready, 0);
        chk("t2_count_full", bus.count, 4);
      end
    end
    chk("t2_count_after5", bus.count, 4);
    chk("t2_valid_stalled", bus.valid_instruction, 1);
    bus.ready_vector = 1'b1;
    wait_issues(4);
    idle(3);
    for (int i = 1; i < 4; i++) chk("t2_back_to_back", issue_q[i], issue_q[i-1] + 1);
    chk("t2_issue_count", issue_q.size(), 4);
    chk("t2_count_end", bus.count, 0);
    chk("t2_valid_end", bus.valid_instruction, 0);
    idle(8);

    // ALU producer -> vs2 reader
    issue_q.delete();
    push(vadd(5'd5, 5'd20, 5'd21, 1'b1));
    p = push_edge;
    push(vadd(5'd6, 5'd22, 5'd5, 1'b1));
    wait_issues(2);
    chk("t3_alu_prod", issue_q[0], p + 1);
    chk("t3_alu_dep", issue_q[1], issue_q[0] + ALU_L);
    idle(8);

    // MUL producer -> vs2 reader
    issue_q.delete();
    push(vmul(5'd5, 5'd20, 5'd21));
    push(vadd(5'd6, 5'd22, 5'd5, 1'b1));
    wait_issues(2);
    chk("t3_mul_dep", issue_q[1], issue_q[0] + MUL_L);
    idle(8);

    // Load vd=7 -> vs1 reader held until load_done(7)
    issue_q.delete();
    push(ins(6'b000000, 1'b1, 5'd0, 5'd1, 3'b000, 5'd7, OP_VL));
    push(vadd(5'd6, 5'd7, 5'd20, 1'b1));
    wait_issues(1);
    idle(4);
    chk("t4_held_valid", bus.valid_instruction, 0);
    chk("t4_held_count", bus.count, 1);
    bus.load_done = 1'b1;
    bus.load_done_id = 5'd8;
    tick();
    bus.load_done = 1'b0;
    tick();
    chk("t4_wrong_id_valid", bus.valid_instruction, 0);
    chk("t4_wrong_id_issues", issue_q.size(), 1);
    bus.load_done = 1'b1;
    bus.load_done_id = 5'd7;
    m = cyc + 1;
    tick();
    bus.load_done = 1'b0;
    wait_issues(2);
    chk("t4_load_release", issue_q[1], m + 1);
    idle(8);

    // v0 producer -> masked op
    issue_q.delete();
    push(vadd(5'd0, 5'd20, 5'd21, 1'b1));
    push(vadd(5'd10, 5'd20, 5'd21, 1'b0));
    wait_issues(2);
    chk("t5_mask_dep", issue_q[1], issue_q[0] + ALU_L);
    idle(8);

    // Flush forces valid low, drops a concurrent push, empties the FIFO
    issue_q.delete();
    bus.ready_vector = 1'b0;
    push(vadd(5'd17, 5'd20, 5'd21, 1'b1));
    push(vadd(5'd18, 5'd20, 5'd21, 1'b1));
    chk("t6_pre_valid", bus.valid_instruction, 1);
    chk("t6_pre_count", bus.count, 2);
    bus.flush      = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = {32'($urandom()), 32'($urandom()), 32'($urandom())};
    exp_q.delete();
    #1;
    chk("t6_flush_valid", bus.valid_instruction, 0);
    tick();
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    chk("t6_flush_count", bus.count, 0);
    chk("t6_flush_ready", bus.push_ready, 1);
    bus.ready_vector = 1'b1;
    tick();
    chk("t6_flush_valid_after", bus.valid_instruction, 0);
    chk("t6_flush_no_issue", issue_q.size(), 0);
    idle(4);

    // Busy v9 survives a flush of three blocked readers
    issue_q.delete();
`ifdef VEC_ISSUE_STATS_EN
    stall0 = stall;
`endif
    push(vmul(5'd9, 5'd20, 5'd21));
    p = push_edge + 1;
    push(vadd(5'd13, 5'd20, 5'd9, 1'b1));
    push(vadd(5'd14, 5'd20, 5'd9, 1'b1));
    push(vadd(5'd15, 5'd20, 5'd9, 1'b1));
    chk("t7_count_queued", bus.count, 3);
    bus.flush = 1'b1;
    exp_q.delete();
    tick();
    bus.flush = 1'b0;
    chk("t7_flush_count", bus.count, 0);
    chk("t7_flush_valid", bus.valid_instruction, 0);
    push(vadd(5'd16, 5'd20, 5'd9, 1'b1));
    wait_issues(2);
    chk("t7_prod_edge", issue_q[0], p);
    chk("t7_reader_after_flush", issue_q[1], p + MUL_L);
`ifdef VEC_ISSUE_STATS_EN
    chk("t7_stall_cycles", stall - stall0, 3);
`endif
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
